// File: rtl/mdu_ctrl.sv
// Multiply/divide unit sequencer for the E stage: latches operands on Start,
// holds Busy for a fixed latency, then commits the result into HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r;
  logic [31:0] hi_r, lo_r, hi_nxt_s, lo_nxt_s;
  logic        busy_r, latch_s;
  logic [63:0] res_s, prod_signed_s, prod_unsigned_s;
  logic [31:0] abs_a_s, abs_b_s, uq_s, ur_s, sq_s, sr_s;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_signed_s   = {{32{a_r[31]}}, a_r} * {{32{b_r[31]}}, b_r};
  assign prod_unsigned_s = {32'd0, a_r} * {32'd0, b_r};

  // Signed division via magnitudes; quotient sign from both operands, remainder from dividend.
  always_comb begin
    abs_a_s = a_r[31] ? (32'd0 - a_r) : a_r;
    abs_b_s = b_r[31] ? (32'd0 - b_r) : b_r;
    uq_s    = 32'd0;
    ur_s    = 32'd0;
    if (b_r != 32'd0) begin
      uq_s = abs_a_s / abs_b_s;
      ur_s = abs_a_s % abs_b_s;
    end else begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end
    sq_s = (a_r[31] ^ b_r[31]) ? (32'd0 - uq_s) : uq_s;
    sr_s = a_r[31] ? (32'd0 - ur_s) : ur_s;
  end

  // Result selected by the latched op; a zero divisor leaves HI/LO untouched.
  always_comb begin
    res_s = {hi_r, lo_r};
    case (op_r)
      OP_MULT:  res_s = prod_signed_s;
      OP_MULTU: res_s = prod_unsigned_s;
      OP_MSUB:  res_s = {hi_r, lo_r} - prod_signed_s;
      OP_DIV:   res_s = (b_r != 32'd0) ? {sr_s, sq_s} : {hi_r, lo_r};
      OP_DIVU:  res_s = (b_r != 32'd0) ? {b_r == 32'd0 ? 32'd0 : a_r % b_r,
                                          b_r == 32'd0 ? 32'd0 : a_r / b_r}
                                       : {hi_r, lo_r};
      default:  res_s = {hi_r, lo_r};
    endcase
  end

  // Next-state, counter and HI/LO update logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    latch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          case (MDUop)
            OP_MULT, OP_MULTU, OP_MSUB: begin
              latch_s     = 1'b1;
              cnt_nxt_s   = MULT_CYCLES[3:0];
              state_nxt_s = RUN;
            end
            OP_DIV, OP_DIVU: begin
              latch_s     = 1'b1;
              cnt_nxt_s   = DIV_CYCLES[3:0];
              state_nxt_s = RUN;
            end
            OP_MTHI: hi_nxt_s = A;
            OP_MTLO: lo_nxt_s = A;
            default: state_nxt_s = IDLE;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
          hi_nxt_s    = res_s[63:32];
          lo_nxt_s    = res_s[31:0];
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, operand and architectural register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      op_r    <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      if (latch_s) begin
        op_r <= MDUop;
        a_r  <= A;
        b_r  <= B;
      end
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver pushes expected commits, a
// negedge monitor pops them whenever Busy falls.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [3:0]  MDUop;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] mhi, mlo, pre_hi, pre_lo;
  int          n_checks = 0;
  int          n_pass = 0;
  logic        busy_prev = 1'b0;
  int          busy_len = 0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUop(MDUop),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural values.
  function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] hi,
                                         input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd7: return {hi, lo} - (sa * sb);
      4'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {hi, lo};
        return {a % b, a / b};
      end
      default: return {hi, lo};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 40) begin
      step();
      n++;
    end
    if (Busy) check("idle_timeout", 64'(Busy), 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    wait_idle();
    pre_hi = mhi;
    pre_lo = mlo;
    Start = 1'b1; MDUop = op; A = a; B = b;
    step();
    Start = 1'b0; MDUop = 4'd0; A = $urandom; B = $urandom;
    case (op)
      4'd1, 4'd2, 4'd7, 4'd3, 4'd4: begin
        r = ref_op(op, a, b, mhi, mlo);
        exp_q.push_back('{r[63:32], r[31:0], (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N});
        mhi = r[63:32];
        mlo = r[31:0];
      end
      4'd5: begin
        mhi = a;
        check("mthi_hi", 64'(HI), 64'(mhi));
        check("mthi_busy", 64'(Busy), 64'd0);
      end
      4'd6: begin
        mlo = a;
        check("mtlo_lo", 64'(LO), 64'(mlo));
        check("mtlo_busy", 64'(Busy), 64'd0);
      end
      default: begin
        check("noop_hilo", {HI, LO}, {mhi, mlo});
        check("noop_busy", 64'(Busy), 64'd0);
      end
    endcase
  endtask

  // Pulse Start mid-operation; it must be ignored and HI/LO must hold.
  task automatic glitch(input int dly, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    repeat (dly) step();
    if (Busy) begin
      Start = 1'b1; MDUop = op; A = a; B = b;
      step();
      Start = 1'b0; MDUop = 4'd0;
      if (Busy) check("run_hold_hilo", {HI, LO}, {pre_hi, pre_lo});
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    exp_q.delete();
    mhi = 32'd0;
    mlo = 32'd0;
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: each falling edge of Busy is a commit to compare against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      busy_prev = 1'b0;
      busy_len  = 0;
    end else begin
      if (Busy) busy_len++;
      else if (busy_prev) begin
        if (exp_q.size() == 0) check("unexpected_commit", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("commit_hi", 64'(HI), 64'(e.hi));
          check("commit_lo", 64'(LO), 64'(e.lo));
          check("busy_len", 64'(busy_len), 64'(e.cycles));
        end
        busy_len = 0;
      end
      busy_prev = Busy;
    end
  end

  initial begin
    logic [3:0] op;
    int n;
    reset = 1'b1; Start = 1'b0; MDUop = 4'd0; A = 32'd0; B = 32'd0;
    mhi = 32'd0; mlo = 32'd0; pre_hi = 32'd0; pre_lo = 32'd0;
    repeat (2) step();
    reset = 1'b0;
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);

    // Reset during a multiply aborts it with no commit.
    issue(4'd1, 32'd3, 32'd4);
    repeat (2) step();
    do_reset(2);
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hilo", {HI, LO}, 64'd0);
    repeat (8) step();
    check("abort_no_commit", {HI, LO}, 64'd0);

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    issue(4'd5, 32'h11, 32'd0);
    issue(4'd6, 32'h22, 32'd0);
    issue(4'd4, 32'd7, 32'd0);
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'd10, 32'd0);
    issue(4'd7, 32'd3, 32'd4);
    issue(4'd1, 32'd2, 32'd2);
    glitch(2, 4'd3, 32'd9, 32'd3);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd4, 32'd20, 32'd6);
    issue(4'd9, 32'd1, 32'd1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 7));
      else op = 4'($urandom_range(0, 15));
      issue(op, rnd_word(), rnd_word());
      if (op >= 4'd1 && op <= 4'd4 || op == 4'd7)
        if ($urandom_range(0, 2) == 0)
          glitch($urandom_range(0, 3), 4'($urandom_range(1, 7)), rnd_word(), rnd_word());
    end

    n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 40) begin
      step();
      n++;
    end
    @(negedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("final_hilo", {HI, LO}, {mhi, mlo});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
